// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of an 8N1 serializer.
// Bytes written through wr_uart are queued; the serializer pops one byte
// whenever it is idle and the FIFO holds data. The serial line is driven
// from a register decoded from the current state, so the line trails the
// state machine by one cycle while every bit keeps its full width.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_uart,
   input  logic [7:0] w_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done_tick,
   output logic       overflow
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_BUSY  = CNT_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Serializer state
   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;

   // FIFO state
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;

   logic              push;
   logic              pop;

   // A write is taken only when there is a free slot at the start of the
   // cycle; a pop in the same cycle does not make room for it.
   assign push = wr_uart && (count_q != CNT_FULL);

   // Serializer next-state: framing, baud timing and bit sequencing.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[head_q];
               baud_d  = '0;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Line level for the next cycle, decoded from the present state.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_q)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   // Serializer registers; reset abandons any frame and idles the line.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // FIFO pointer/occupancy update and sticky overflow detection.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) begin
         tail_d = tail_q + PTR_ONE;
      end
      if (pop) begin
         head_d = head_q + PTR_ONE;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (wr_uart && (count_q == CNT_FULL)) begin
         overflow_d = 1'b1;
      end
   end

   // FIFO control registers; buffered bytes are discarded by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Byte storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_q[tail_q] <= w_data;
      end
   end

   assign tx           = tx_q;
   assign tx_busy      = (count_q >= CNT_BUSY);
   assign tx_done_tick = (state_q == STOP) && (baud_q == BAUD_LAST);
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with 4 clocks per bit and a 4-deep FIFO.
// Stimulus pushes expected bytes into a queue; a line monitor decodes the
// serial output, checks bit widths, framing, the inter-frame idle cycle and
// the done pulse position, and pops the queue for every received frame.
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_uart = 1'b0;
   logic [7:0] w_data = 8'h00;
   logic       tx;
   logic       tx_busy;
   logic       tx_done_tick;
   logic       overflow;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] sb [$];
   int         start_cyc [$];

   // Line monitor state
   logic       in_frame = 1'b0;
   logic       prev_tx  = 1'b1;
   logic       shape_ok = 1'b1;
   logic [9:0] bits     = '0;
   int         k        = 0;
   int         nframes  = 0;

   uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_uart     (wr_uart),
      .w_data      (w_data),
      .tx          (tx),
      .tx_busy     (tx_busy),
      .tx_done_tick(tx_done_tick),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Decode the serial line on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      logic exp_done;
      logic [7:0] exp_byte;
      int j;
      if (reset) begin
         in_frame = 1'b0;
         prev_tx  = 1'b1;
      end else begin
         if (!in_frame) begin
            if (prev_tx && (tx === 1'b0)) begin
               in_frame = 1'b1;
               k        = 1;
               shape_ok = 1'b1;
               bits     = '0;
               start_cyc.push_back(cyc);
            end
         end else begin
            k++;
            if (k <= FRAME) begin
               j = (k - 1) / CPB;
               if (((k - 1) % CPB) == 0) begin
                  bits[j] = tx;
               end else if (tx !== bits[j]) begin
                  shape_ok = 1'b0;
               end
            end
            if (k == FRAME) begin
               nframes++;
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_frame got=%0h exp=none", bits);
               end else begin
                  exp_byte = sb.pop_front();
                  $display("frame %0d: byte=%02h expected=%02h", nframes, bits[8:1], exp_byte);
                  check("frame", {21'd0, shape_ok, bits}, {21'd0, 1'b1, 1'b1, exp_byte, 1'b0});
               end
            end
         end
         exp_done = in_frame && (k == FRAME - 1);
         if (tx_done_tick || exp_done) begin
            check("done_tick", tx_done_tick, exp_done);
         end
         if (in_frame && (k == FRAME + 1)) begin
            check("idle_gap", tx, 1'b1);
            in_frame = 1'b0;
         end
         prev_tx = tx;
      end
   end

   task automatic wr(input logic [7:0] d, input bit accept);
      wr_uart = 1'b1;
      w_data  = d;
      if (accept) sb.push_back(d);
      @(posedge clk);
      #1;
      wr_uart = 1'b0;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      wr_uart = 1'b1;
      w_data  = 8'h3C;
      sb.delete();
      @(posedge clk);
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_done", tx_done_tick, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      wr_uart = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      logic pending;
      while ((sb.size() != 0 || in_frame) && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      pending = (sb.size() != 0) || in_frame;
      check("drain_timeout", pending, 1'b0);
      sb.delete();
      repeat (5) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d5 [5];
      logic       busy5 [5];
      logic       ovf6 [6];
      int         seen;
      int         period;

      // Reset with a write strobe held high: nothing may be queued.
      do_reset();
      repeat (60) @(posedge clk);
      #1;

      // Single byte: line idles for two edges, then the 0xA5 frame.
      wr(8'hA5, 1);
      check("lat_e0_tx", tx, 1'b1);
      check("lat_e0_busy", tx_busy, 1'b0);
      @(posedge clk);
      #1;
      check("lat_e1_tx", tx, 1'b1);
      @(posedge clk);
      #1;
      check("lat_e2_tx", tx, 1'b0);
      wait_idle();

      // Two back-to-back bytes: one idle cycle between frames.
      start_cyc.delete();
      wr(8'h01, 1);
      wr(8'h80, 1);
      check("b2b_overflow_early", overflow, 1'b0);
      wait_idle();
      period = (start_cyc.size() >= 2) ? (start_cyc[1] - start_cyc[0]) : -1;
      check("b2b_period", period, FRAME + 1);
      check("b2b_overflow", overflow, 1'b0);

      // Five writes: first popped at once, busy once three are held.
      d5    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      busy5 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         wr(d5[i], 1);
         check("five_busy", tx_busy, busy5[i]);
      end
      wait_idle();
      check("five_overflow", overflow, 1'b0);

      // Six writes: the sixth is dropped and overflow sticks.
      ovf6 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         wr(8'h60 + 8'(i), (i < 5));
         check("six_overflow", overflow, ovf6[i]);
      end
      wait_idle();
      check("six_overflow_sticky", overflow, 1'b1);
      do_reset();

      // Write on the same cycle as an IDLE pop while three bytes are held.
      for (int i = 0; i < 5; i++) begin
         wr(8'h51 + 8'(i), 1);
      end
      seen = 0;
      for (int i = 0; i < 300 && seen < 2; i++) begin
         @(posedge clk);
         #1;
         if (tx_done_tick) seen++;
      end
      check("pop_done_wait", seen, 2);
      @(posedge clk);
      #1;
      check("pop_busy_before", tx_busy, 1'b1);
      wr(8'h56, 1);
      check("pop_busy_after", tx_busy, 1'b1);
      check("pop_overflow", overflow, 1'b0);
      wait_idle();

      // Reset during data bit 3 with two bytes buffered.
      wr(8'hF7, 1);
      wr(8'hC1, 1);
      wr(8'hC2, 1);
      repeat (16) @(posedge clk);
      #1;
      check("mid_tx_bit3", tx, 1'b0);
      check("mid_busy", tx_busy, 1'b0);
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      check("mid_rst_tx", tx, 1'b1);
      check("mid_rst_busy", tx_busy, 1'b0);
      check("mid_rst_done", tx_done_tick, 1'b0);
      reset = 1'b0;
      repeat (150) @(posedge clk);
      #1;
      check("mid_quiet_tx", tx, 1'b1);
      wr(8'h3E, 1);
      check("post_busy", tx_busy, 1'b0);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries in the holding FIFO (power of two, >= 4).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_uart  input  1  write strobe; one byte accepted per cycle it is high.
REQ-006 SHALL have port w_data  input  8  byte written when wr_uart is high.
REQ-007 SHALL have port tx  output  1  serial line; idle high.
REQ-008 SHALL have port tx_busy  output  1  high when the FIFO cannot guarantee room for two more bytes.
REQ-009 SHALL have port tx_done_tick  output  1  one-cycle pulse when a stop bit completes.
REQ-010 SHALL have port overflow  output  1  sticky flag, set when a write is dropped.

Function
REQ-011 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with each bit held for exactly CLKS_PER_BIT cycles.
REQ-012 SHALL implement states IDLE, START, DATA and STOP with these transitions:
- IDLE->START when the FIFO is non-empty; this pops the head byte into the shift register.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bits.
- STOP->IDLE after CLKS_PER_BIT cycles.
REQ-013 SHALL drive tx from a register: 1 in IDLE and STOP, 0 in START, and shift-register bit 0 in DATA.
REQ-014 SHALL use a baud counter that counts 0..CLKS_PER_BIT-1, resets to 0 on every bit boundary, and has width clog2(CLKS_PER_BIT).
REQ-015 SHALL use a 3-bit bit counter that counts 0..7 in DATA and shifts the shift register right at each bit boundary.
REQ-016 SHALL accept a write when wr_uart=1 and count<FIFO_DEPTH; the byte is stored at the tail and the tail pointer advances modulo FIFO_DEPTH.
REQ-017 SHALL drop a write made when count==FIFO_DEPTH, even if a pop occurs in the same cycle, and set overflow=1 on the next edge.
REQ-018 SHALL leave count unchanged when an accepted write and a pop occur in the same cycle; both pointers advance.
REQ-019 SHALL assert tx_busy = (count >= FIFO_DEPTH-1), decoded from registered count only, so that a write made while tx_busy=0, followed by one unconditional write, never overflows.
REQ-020 SHALL make the first byte reach the line with this latency: tx falls at the second rising edge after the edge that samples wr_uart into an empty FIFO while in IDLE.
REQ-021 SHALL insert exactly one IDLE cycle (tx=1) between consecutive frames, giving 10*CLKS_PER_BIT+1 cycles per byte under back-to-back load.
REQ-022 SHALL pulse tx_done_tick high for exactly the final cycle of each STOP state.
REQ-023 SHALL accept writes during any state; FIFO operation SHALL NOT depend on serializer state.
REQ-024 SHALL clear overflow only on reset.

Reset
REQ-025 SHALL, while reset=1, force the following on the next rising edge:
- state=IDLE, tx=1
- FIFO pointers and count = 0
- baud and bit counters = 0
- tx_busy=0, tx_done_tick=0, overflow=0
REQ-026 SHALL abandon any frame in progress on reset: tx returns high on the next edge, and buffered or in-flight bytes are discarded without a tx_done_tick.
REQ-027 SHALL ignore wr_uart during any cycle in which reset=1.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 SHALL cover a single write of 0xA5 in IDLE:
- tx=1 for 2 edges, then bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles.
- tx_done_tick pulses once, in cycle 40 of the frame.
REQ-029 SHALL cover two writes on consecutive cycles, 0x01 then 0x80, the second ignoring tx_busy:
- both frames are sent in order, separated by 1 idle cycle.
- overflow stays 0.
REQ-030 SHALL cover 5 writes on consecutive cycles into an empty FIFO while IDLE:
- the first is popped, and the next 3 are buffered, so tx_busy=1 once count=3.
- all 5 bytes are sent, overflow=0.
REQ-031 SHALL cover 6 writes on consecutive cycles:
- the 6th write is dropped and overflow=1.
- exactly 5 frames are sent.
- overflow stays 1 until reset.
REQ-032 SHALL cover reset asserted during data bit 3 with 2 bytes buffered:
- tx=1 on the next edge.
- count=0 and tx_busy=0.
- no further frames and no tx_done_tick.
REQ-033 SHALL cover a write made on the same cycle as an IDLE pop with count=3:
- count stays 3 and tx_busy stays 1.
- byte order is preserved.
